// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon Says controller: FSM encodings,
// LFSR seed/taps and the colour one-hot helper.
package simon_pkg;

   typedef logic [3:0] state_t;

   localparam state_t S_READY       = 4'd0;
   localparam state_t S_ARM         = 4'd1;
   localparam state_t S_ADD_CLR     = 4'd2;
   localparam state_t S_PLAY_ON     = 4'd3;
   localparam state_t S_PLAY_OFF    = 4'd4;
   localparam state_t S_PLAYER_TURN = 4'd5;
   localparam state_t S_DESELECT    = 4'd6;
   localparam state_t S_GOOD_TURN   = 4'd7;
   localparam state_t S_FAIL_ON     = 4'd8;
   localparam state_t S_FAIL_OFF    = 4'd9;
   localparam state_t S_WIN         = 4'd10;
   localparam state_t S_LOST        = 4'd11;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Right-shifting form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   // Colour-index width; CLR_W in the top is clr_w(NUM_CLR).
   function automatic int clr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [7:0] onehot(input logic [2:0] c);
      return 8'b1 << c;
   endfunction

endpackage

// File: rtl/simon_lfsr.sv
// 16-bit Fibonacci LFSR used as the colour source for the Simon sequence.
module simon_lfsr
   import simon_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   output logic [15:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)   q <= LFSR_SEED;
      else if (en) q <= {^(q & LFSR_TAPS), q[15:1]};
   end

endmodule

// File: rtl/simon_game_ctrl.sv
// Simon Says game controller: sequence generation, paced playback, player check.
// Optional speed-up/boost logic is built when SIMON_SPEEDUP_EN is defined.
module simon_game_ctrl
   import simon_pkg::*;
#(
   parameter int NUM_CLR      = 4,
   parameter int MAX_ROUNDS   = 32,
   parameter int SPEED_STEP   = 4,
   parameter int FAIL_FLASHES = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         launch_keys,
   input  logic [NUM_CLR-1:0] player_input,
   input  logic               pulse,
   output logic [NUM_CLR-1:0] led_out,
   output logic [5:0]         current_round,
   output logic [1:0]         speed,
   output logic               game_won,
   output logic               game_lost,
   output logic               busy
);

   localparam int CLR_W = clr_w(NUM_CLR);
   localparam int AW    = clr_w(MAX_ROUNDS);

   state_t             state, nxt;
   logic [5:0]         len, idx, idx_inc;
   logic [1:0]         fail_cnt, fail_inc;
   logic [15:0]        lfsr_q;
   logic [7:0]         unused_lfsr_hi;
   logic [CLR_W-1:0]   new_clr, cur_clr;
   logic [NUM_CLR-1:0] cur_oh;
   logic               arm_release;

   // Sequence memory is deliberately unreset; len=0 masks stale entries.
   logic [CLR_W-1:0]   seq_mem [MAX_ROUNDS];

   simon_lfsr u_lfsr (
      .clk   (clk),
      .reset (reset),
      .en    (1'b1),
      .q     (lfsr_q)
   );

   assign unused_lfsr_hi = lfsr_q[15:8];
   assign new_clr  = CLR_W'(lfsr_q[7:0] % 8'(NUM_CLR));
   assign cur_clr  = seq_mem[idx[AW-1:0]];
   assign cur_oh   = NUM_CLR'(onehot(3'(cur_clr)));
   assign idx_inc  = idx + 6'd1;
   assign fail_inc = fail_cnt + 2'd1;

`ifdef SIMON_SPEEDUP_EN
   assign arm_release = (launch_keys == 2'b00);
`else
   logic unused_boost_key;
   assign unused_boost_key = launch_keys[1];
   assign arm_release      = !launch_keys[0];
`endif

   always_comb begin
      nxt = state;
      case (state)
         S_READY:       if (launch_keys[0]) nxt = S_ARM;
         S_ARM:         if (arm_release) nxt = S_ADD_CLR;
         S_ADD_CLR:     nxt = S_PLAY_ON;
         S_PLAY_ON:     if (pulse) nxt = S_PLAY_OFF;
         S_PLAY_OFF:    if (pulse) nxt = (idx_inc == len) ? S_PLAYER_TURN : S_PLAY_ON;
         S_PLAYER_TURN: if (player_input != '0)
                           nxt = (player_input == cur_oh) ? S_DESELECT : S_FAIL_ON;
         S_DESELECT:    if (player_input == '0)
                           nxt = (idx_inc == len) ? S_GOOD_TURN : S_PLAYER_TURN;
         S_GOOD_TURN:   nxt = (len == 6'(MAX_ROUNDS)) ? S_WIN : S_ADD_CLR;
         S_FAIL_ON:     if (pulse) nxt = S_FAIL_OFF;
         S_FAIL_OFF:    if (pulse) nxt = (fail_inc == 2'(FAIL_FLASHES)) ? S_LOST : S_FAIL_ON;
         S_WIN, S_LOST: nxt = state;
         default:       nxt = S_READY;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_READY;
         len      <= '0;
         idx      <= '0;
         fail_cnt <= '0;
      end else begin
         state <= nxt;
         case (state)
            S_ADD_CLR: begin
               len <= len + 6'd1;
               idx <= '0;
            end
            S_PLAY_OFF: if (pulse) idx <= (idx_inc == len) ? 6'd0 : idx_inc;
            S_DESELECT: if (player_input == '0) idx <= idx_inc;
            S_FAIL_OFF: if (pulse) fail_cnt <= fail_inc;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == S_ADD_CLR) seq_mem[len[AW-1:0]] <= new_clr;
   end

   // Outputs decode the current state register, so they trail transitions by a cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         led_out       <= '0;
         current_round <= '0;
         game_won      <= 1'b0;
         game_lost     <= 1'b0;
         busy          <= 1'b0;
      end else begin
         busy      <= !(state inside {S_READY, S_WIN, S_LOST});
         game_won  <= (state == S_WIN);
         game_lost <= (state == S_LOST);
         case (state)
            S_PLAY_ON:                 led_out <= cur_oh;
            S_PLAYER_TURN, S_DESELECT: led_out <= player_input;
            S_FAIL_ON, S_WIN:          led_out <= '1;
            default:                   led_out <= '0;
         endcase
         if (state == S_GOOD_TURN)    current_round <= len;
         else if (state == S_FAIL_ON) current_round <= len - 6'd1;
      end
   end

`ifdef SIMON_SPEEDUP_EN
   logic boost;
   logic step_hit;

   assign step_hit = ((len % 6'(SPEED_STEP)) == 6'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         boost <= 1'b0;
         speed <= 2'd0;
      end else begin
         if (state == S_ARM && launch_keys[1]) boost <= 1'b1;
         if (state == S_ARM && arm_release)
            speed <= boost ? 2'd1 : 2'd0;
         else if (state == S_GOOD_TURN && step_hit && speed != 2'd3)
            speed <= speed + 2'd1;
      end
   end
`else
   assign speed = 2'd0;
`endif

endmodule
